// File: rtl/led_matrix_pkg.sv
// Shared types and sizing helpers for the LED matrix row scanner.
package led_matrix_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } scan_state_t;

    localparam int DEFAULT_PWM_BITS = 2;

    typedef logic [DEFAULT_PWM_BITS-1:0] level_t;

    function automatic int row_idx_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int cnt_width(input int blank_cycles, input int dwell_cycles);
        int longest;
        longest = (blank_cycles > dwell_cycles) ? blank_cycles : dwell_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/led_row_timer.sv
// BLANK/SCAN phase timer for one row, with PWM slot tracking and row/frame pulses.
module led_row_timer
    import led_matrix_pkg::*;
#(
    parameter int ROWS         = 8,
    parameter int PWM_BITS     = DEFAULT_PWM_BITS,
    parameter int DWELL_CYCLES = 131072,
    parameter int BLANK_CYCLES = 64,
    localparam int RW          = row_idx_width(ROWS)
) (
    input  logic                clk,
    input  logic                reset,
    output scan_state_t         state,
    output logic                phase_start,
    output logic                scan_next,
    output logic [PWM_BITS-1:0] slot_next,
    output logic [RW-1:0]       row_idx,
    output logic                row_advance,
    output logic                wrap
);

    localparam int CW   = cnt_width(BLANK_CYCLES, DWELL_CYCLES);
    localparam int SLOT = DWELL_CYCLES >> PWM_BITS;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    logic [CW-1:0]       cnt, cnt_nxt;
    logic [CW-1:0]       sub, sub_nxt;
    logic [PWM_BITS-1:0] slot, slot_nxt;
    scan_state_t         state_nxt;
    logic                phase_last;

    // The slot is tracked with its own sub-counter so SLOT need not be a power of two.
    always_comb begin
        phase_last = (state == BLANK) ? (cnt == BLANK_LAST) : (cnt == DWELL_LAST);
        state_nxt  = state;
        cnt_nxt    = cnt + 1'b1;
        sub_nxt    = '0;
        slot_nxt   = '0;
        if (phase_last) begin
            cnt_nxt   = '0;
            state_nxt = (state == BLANK) ? SCAN : BLANK;
        end else if (state == SCAN) begin
            if (sub == SLOT_LAST) begin
                sub_nxt  = '0;
                slot_nxt = slot + 1'b1;
            end else begin
                sub_nxt  = sub + 1'b1;
                slot_nxt = slot;
            end
        end
    end

    assign row_advance = (state == SCAN) && phase_last;
    assign wrap        = row_advance && (row_idx == ROW_LAST);
    assign phase_start = (cnt == '0);
    assign scan_next   = (state_nxt == SCAN);
    assign slot_next   = slot_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= BLANK;
            cnt     <= '0;
            sub     <= '0;
            slot    <= '0;
            row_idx <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sub   <= sub_nxt;
            slot  <= slot_nxt;
            if (row_advance) begin
                row_idx <= (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Row-scanning LED matrix driver: shadow/active frame buffers, one-hot rows, PWM columns.
// Define LED_TESTMODE_EN to add the test_mode lamp-test input (all pixels at full level).
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int PWM_BITS     = DEFAULT_PWM_BITS,
    parameter int DWELL_CYCLES = 131072,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ROWS*COLS*PWM_BITS-1:0] frame_flat,
    input  logic                         frame_valid,
`ifdef LED_TESTMODE_EN
    input  logic                         test_mode,
`endif
    output logic                         frame_ready,
    output logic                         frame_start,
    output logic [ROWS-1:0]              row,
    output logic [COLS-1:0]              col_n
);

    localparam int FW = ROWS * COLS * PWM_BITS;
    localparam int RW = row_idx_width(ROWS);

    scan_state_t         state;
    logic                phase_start;
    logic                scan_next;
    logic [PWM_BITS-1:0] slot_next;
    logic [RW-1:0]       row_idx;
    logic                row_advance;
    logic                wrap;

    logic [FW-1:0]       active_buf;
    logic [FW-1:0]       shadow_buf;
    logic                pending;
    logic [COLS-1:0]     col_nxt;
    logic [PWM_BITS-1:0] lvl;

    led_row_timer #(
        .ROWS         (ROWS),
        .PWM_BITS     (PWM_BITS),
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .phase_start (phase_start),
        .scan_next   (scan_next),
        .slot_next   (slot_next),
        .row_idx     (row_idx),
        .row_advance (row_advance),
        .wrap        (wrap)
    );

    // Columns are computed for the coming cycle so they register on the same edge as row.
    // Row only changes on a SCAN->BLANK edge, where the columns go dark anyway.
    always_comb begin
        col_nxt = '1;
        lvl     = '0;
        if (scan_next) begin
            for (int c = 0; c < COLS; c++) begin
                lvl = active_buf[(int'(row_idx) * COLS + c) * PWM_BITS +: PWM_BITS];
`ifdef LED_TESTMODE_EN
                if (test_mode) lvl = '1;
`endif
                col_nxt[c] = !(lvl > slot_next);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row        <= {{(ROWS-1){1'b0}}, 1'b1};
            col_n      <= '1;
            active_buf <= '0;
            shadow_buf <= '0;
            pending    <= 1'b0;
        end else begin
            col_n <= col_nxt;
            if (row_advance) begin
                row <= {row[ROWS-2:0], row[ROWS-1]};
            end
            // Capture on a wrap edge cannot coincide with a swap: capture needs pending low.
            if (wrap && pending) begin
                active_buf <= shadow_buf;
                pending    <= 1'b0;
            end else if (frame_valid && !pending) begin
                shadow_buf <= frame_flat;
                pending    <= 1'b1;
            end
        end
    end

    assign frame_ready = !pending;
    assign frame_start = reset && (state == BLANK) && phase_start && (row_idx == '0);

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed + randomized bench for led_matrix_scan against a cycle-position reference model.
module tb_led_matrix_scan;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int PB     = 2;
    localparam int DWELL  = 8;
    localparam int BLANK  = 2;
    localparam int SLOT   = DWELL >> PB;
    localparam int ROW_T  = BLANK + DWELL;
    localparam int FRAME  = ROWS * ROW_T;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [ROWS*COLS*PB-1:0]   frame_flat = '0;
    logic                      frame_valid = 1'b0;
    logic                      frame_ready;
    logic                      frame_start;
    logic [ROWS-1:0]           row;
    logic [COLS-1:0]           col_n;
`ifdef LED_TESTMODE_EN
    logic                      test_mode = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state: cycle index since reset release and the two frame words.
    int          t = 0;
    logic [31:0] m_active = '0;
    logic [31:0] m_shadow = '0;
    bit          m_pending = 1'b0;

    always #5 clk = ~clk;

    led_matrix_scan #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .PWM_BITS     (PB),
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_flat  (frame_flat),
        .frame_valid (frame_valid),
`ifdef LED_TESTMODE_EN
        .test_mode   (test_mode),
`endif
        .frame_ready (frame_ready),
        .frame_start (frame_start),
        .row         (row),
        .col_n       (col_n)
    );

    function automatic int level_of(input logic [31:0] w, input int r, input int c);
        return int'((w >> ((r * COLS + c) * PB)) & 32'h3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int pos, r, ph, s;
        logic [31:0] exp_col;
        pos = t % FRAME;
        r   = pos / ROW_T;
        ph  = pos % ROW_T;
        exp_col = 32'hF;
        if (ph >= BLANK) begin
            s = (ph - BLANK) / SLOT;
            for (int c = 0; c < COLS; c++) begin
                if (level_of(m_active, r, c) > s) exp_col[c] = 1'b0;
            end
        end
        check("row", 32'(row), 32'(1 << r));
        check("col_n", 32'(col_n), exp_col);
        check("frame_start", 32'(frame_start), 32'(pos == 0));
        check("frame_ready", 32'(frame_ready), 32'(!m_pending));
    endtask

    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        if ((t % FRAME) == FRAME - 1 && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end else if (frame_valid && !m_pending) begin
            m_shadow  = frame_flat;
            m_pending = 1'b1;
        end
        t++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while ((t % FRAME) != target && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
    endtask

    task automatic send(input logic [31:0] data);
        frame_valid = 1'b1;
        frame_flat  = data;
        tick();
        frame_valid = 1'b0;
        frame_flat  = $urandom;
    endtask

    task automatic model_reset();
        t         = 0;
        m_active  = '0;
        m_shadow  = '0;
        m_pending = 1'b0;
    endtask

    initial begin
        // Held in reset: outputs at their reset values.
        #12;
        check("rst_row", 32'(row), 32'h1);
        check("rst_col_n", 32'(col_n), 32'hF);
        check("rst_ready", 32'(frame_ready), 32'h1);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // One dark frame plus the start of the next.
        run(FRAME + 1);

        // All levels 3 mid-frame, then a second valid while not ready.
        run_to(15);
        send(32'hFFFF_FFFF);
        send($urandom);
        run_to(0);
        run(FRAME + 5);

        // Single pixel (1,2) = 1.
        run_to(20);
        send(32'h0000_1000);
        run_to(0);
        run(FRAME + 5);

        // Valid exactly on the wrap cycle with nothing pending.
        run_to(FRAME - 1);
        send($urandom);
        run(2 * FRAME + 5);

        // Random traffic.
        repeat (300) begin
            frame_valid = ($urandom_range(0, 9) == 0);
            frame_flat  = $urandom;
            tick();
        end
        frame_valid = 1'b0;
        run(FRAME + 1);

        // Bright frame, then reset in the middle of SCAN on row 2.
        send(32'hFFFF_FFFF);
        run_to(0);
        run_to(2 * ROW_T + 5);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_row", 32'(row), 32'h1);
        check("midrst_col_n", 32'(col_n), 32'hF);
        check("midrst_ready", 32'(frame_ready), 32'h1);
        check("midrst_frame_start", 32'(frame_start), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        run(FRAME + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
